// File: rtl/add_pkg.sv
// Shared types and constants for the pipelined add/accumulate controller.
// Holds the datapath width, the operand beat record and the overflow rule.
package add_pkg;

   localparam int unsigned DATA_W = 32;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic              cin;
      logic              acc;
      logic              clr;
   } beat_t;

   // Signed overflow: operands agree in sign but the result sign differs.
   function automatic logic calc_ovf(logic a_msb, logic b_msb, logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/add_pipe_ctrl_csa.sv
// 32-bit square-root carry-select adder (SquareRootCSA).
// Blocks widen towards the MSB so each block sum is ready before its select carry.
module SquareRootCSA
   import add_pkg::*;
(
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic              cin_i,
   output logic [DATA_W:0]   sum_o
);

   localparam int unsigned NumBlk = 6;

   function automatic int unsigned blk_w(int unsigned idx);
      case (idx)
         0, 1:    return 4;
         2:       return 5;
         3, 4:    return 6;
         default: return 7;
      endcase
   endfunction

   function automatic int unsigned blk_lo(int unsigned idx);
      int unsigned lo;
      lo = 0;
      for (int unsigned j = 0; j < idx; j++) lo += blk_w(j);
      return lo;
   endfunction

   logic [NumBlk:0] carry;

   assign carry[0] = cin_i;

   for (genvar gi = 0; gi < NumBlk; gi++) begin : g_blk
      localparam int unsigned Lo = blk_lo(gi);
      localparam int unsigned W  = blk_w(gi);

      logic [W:0] r0;
      logic [W:0] r1;

      // Both candidate sums are formed in parallel; the incoming carry only selects.
      assign r0 = {1'b0, a_i[Lo +: W]} + {1'b0, b_i[Lo +: W]};
      assign r1 = {1'b0, a_i[Lo +: W]} + {1'b0, b_i[Lo +: W]} + {{W{1'b0}}, 1'b1};
      assign {carry[gi+1], sum_o[Lo +: W]} = carry[gi] ? r1 : r0;
   end

   assign sum_o[DATA_W] = carry[NumBlk];

endmodule

// File: rtl/add_pipe_ctrl.sv
// Two-stage valid/ready add pipeline with an accumulator and a hand-off counter.
// S1 holds the operand beat, S2 the registered result; acc is read at the S1->S2 move.
module add_pipe_ctrl
   import add_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic              in_cin,
   input  logic              in_acc,
   input  logic              in_clr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W:0]   out_sum,
   output logic              out_ovf,
   output logic [DATA_W-1:0] acc,
   output logic [CNT_W-1:0]  res_cnt
);

   beat_t             s1_q, s1_d;
   logic              s1_v_q, s1_v_d;
   logic              s2_v_q, s2_v_d;
   logic [DATA_W:0]   sum_q, sum_d;
   logic              ovf_q, ovf_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              s2_adv;
   logic              s1_xfer;
   logic              accept;
   logic [DATA_W-1:0] a_eff;
   logic [DATA_W:0]   add_sum;

   assign s2_adv  = !s2_v_q || out_ready;
   assign s1_xfer = s2_adv && s1_v_q;
   assign in_ready = !s1_v_q || s2_adv;
   assign accept  = in_valid && in_ready;

   // Accumulator is sampled here, so back-to-back acc beats see the freshest value.
   assign a_eff = s1_q.clr ? '0 : (s1_q.acc ? acc_q : s1_q.a);

   SquareRootCSA u_csa (
      .a_i   (a_eff),
      .b_i   (s1_q.b),
      .cin_i (s1_q.cin),
      .sum_o (add_sum)
   );

   always_comb begin
      s1_d   = s1_q;
      s1_v_d = s1_v_q;
      s2_v_d = s2_v_q;
      sum_d  = sum_q;
      ovf_d  = ovf_q;
      acc_d  = acc_q;
      cnt_d  = cnt_q;

      if (accept) begin
         s1_d   = '{a: in_a, b: in_b, cin: in_cin, acc: in_acc, clr: in_clr};
         s1_v_d = 1'b1;
      end else if (s1_xfer) begin
         s1_v_d = 1'b0;
      end

      if (s2_adv) s2_v_d = s1_v_q;

      if (s1_xfer) begin
         sum_d = add_sum;
         ovf_d = calc_ovf(a_eff[DATA_W-1], s1_q.b[DATA_W-1], add_sum[DATA_W-1]);
         acc_d = add_sum[DATA_W-1:0];
      end

      if (s2_v_q && out_ready) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q   <= '0;
         s1_v_q <= 1'b0;
         s2_v_q <= 1'b0;
         sum_q  <= '0;
         ovf_q  <= 1'b0;
         acc_q  <= '0;
         cnt_q  <= '0;
      end else begin
         s1_q   <= s1_d;
         s1_v_q <= s1_v_d;
         s2_v_q <= s2_v_d;
         sum_q  <= sum_d;
         ovf_q  <= ovf_d;
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
      end
   end

   assign out_valid = s2_v_q;
   assign out_sum   = sum_q;
   assign out_ovf   = ovf_q;
   assign acc       = acc_q;
   assign res_cnt   = cnt_q;

endmodule

// File: tb/tb_add_pipe_ctrl.sv
// Directed bench for add_pipe_ctrl: carry/overflow, accumulate chain, back-pressure,
// mid-flight reset and counter wrap, all against hand-computed values.
module tb_add_pipe_ctrl;

   localparam int CntW = 8;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_a;
   logic [31:0]       in_b;
   logic              in_cin;
   logic              in_acc;
   logic              in_clr;
   logic              out_valid;
   logic              out_ready;
   logic [32:0]       out_sum;
   logic              out_ovf;
   logic [31:0]       acc;
   logic [CntW-1:0]   res_cnt;

   int n_vec;
   int n_err;

   add_pipe_ctrl #(.CNT_W(CntW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .in_acc    (in_acc),
      .in_clr    (in_clr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_ovf   (out_ovf),
      .acc       (acc),
      .res_cnt   (res_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
      in_cin = 1'b0;
      in_acc = 1'b0;
      in_clr = 1'b0;
   endtask

   task automatic pulse_reset();
      idle_inputs();
      rst = 1'b1;
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_in_ready got %0b want 1", in_ready);
      end
      n_vec++;
      if (out_valid !== 1'b0 || out_sum !== 33'd0 || out_ovf !== 1'b0) begin
         n_err++; $display("FAIL reset_out got v=%0b s=%h o=%0b want 0", out_valid, out_sum,
                           out_ovf);
      end
      n_vec++;
      if (acc !== 32'd0 || res_cnt !== '0) begin
         n_err++; $display("FAIL reset_state got acc=%h cnt=%0d want 0", acc, res_cnt);
      end
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_carry();
      out_ready = 1'b1;
      in_valid = 1'b1; in_a = 32'hFFFF_FFFF; in_b = 32'd1; in_cin = 1'b0;
      step();
      idle_inputs();
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++; $display("FAIL carry_early_valid got %0b want 0", out_valid);
      end
      step();
      n_vec++;
      if (out_valid !== 1'b1 || out_sum !== 33'h1_0000_0000 || out_ovf !== 1'b0) begin
         n_err++; $display("FAIL carry_result got v=%0b s=%h o=%0b want 1 100000000 0",
                           out_valid, out_sum, out_ovf);
      end
      step();
      n_vec++;
      if (out_valid !== 1'b0 || res_cnt !== 8'd1) begin
         n_err++; $display("FAIL carry_handoff got v=%0b cnt=%0d want 0 1", out_valid, res_cnt);
      end
   endtask

   task automatic test_overflow();
      in_valid = 1'b1; in_a = 32'h7FFF_FFFF; in_b = 32'd1; in_cin = 1'b0;
      step();
      idle_inputs();
      step();
      n_vec++;
      if (out_valid !== 1'b1 || out_sum !== 33'h0_8000_0000 || out_ovf !== 1'b1) begin
         n_err++; $display("FAIL ovf_result got v=%0b s=%h o=%0b want 1 080000000 1",
                           out_valid, out_sum, out_ovf);
      end
      n_vec++;
      if (acc !== 32'h8000_0000) begin
         n_err++; $display("FAIL ovf_acc got %h want 80000000", acc);
      end
      step();
   endtask

   task automatic test_acc_chain();
      logic [32:0] exp_sum [4];
      exp_sum[0] = 33'd5; exp_sum[1] = 33'd8; exp_sum[2] = 33'd11; exp_sum[3] = 33'd14;
      pulse_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_a = 32'hDEAD_BEEF;
         in_b = (i == 0) ? 32'd5 : 32'd3;
         in_clr = (i == 0);
         in_acc = (i != 0);
         step();
         if (i >= 1) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_sum !== exp_sum[i-1]) begin
               n_err++; $display("FAIL chain_sum%0d got v=%0b s=%0d want 1 %0d", i - 1,
                                 out_valid, out_sum, exp_sum[i-1]);
            end
         end
      end
      idle_inputs();
      step();
      n_vec++;
      if (out_sum !== exp_sum[3] || acc !== 32'd14) begin
         n_err++; $display("FAIL chain_last got s=%0d acc=%0d want 14 14", out_sum, acc);
      end
      step();
      n_vec++;
      if (res_cnt !== 8'd4 || out_valid !== 1'b0) begin
         n_err++; $display("FAIL chain_cnt got cnt=%0d v=%0b want 4 0", res_cnt, out_valid);
      end
   endtask

   task automatic test_backpressure();
      pulse_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_a = 32'd100; in_b = 32'd10;
      step();
      in_b = 32'd20;
      step();
      in_b = 32'd30;
      for (int c = 0; c < 4; c++) begin
         n_vec++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 33'd110) begin
            n_err++; $display("FAIL bp_hold%0d got rdy=%0b v=%0b s=%0d want 0 1 110", c,
                              in_ready, out_valid, out_sum);
         end
         if (c < 3) step();
      end
      out_ready = 1'b1;
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL bp_ready_comb got %0b want 1", in_ready);
      end
      step();
      idle_inputs();
      n_vec++;
      if (out_valid !== 1'b1 || out_sum !== 33'd120) begin
         n_err++; $display("FAIL bp_beat1 got v=%0b s=%0d want 1 120", out_valid, out_sum);
      end
      step();
      n_vec++;
      if (out_valid !== 1'b1 || out_sum !== 33'd130) begin
         n_err++; $display("FAIL bp_beat2 got v=%0b s=%0d want 1 130", out_valid, out_sum);
      end
      step();
      n_vec++;
      if (out_valid !== 1'b0 || res_cnt !== 8'd3) begin
         n_err++; $display("FAIL bp_drain got v=%0b cnt=%0d want 0 3", out_valid, res_cnt);
      end
   endtask

   task automatic test_reset_mid();
      pulse_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_a = 32'd7; in_b = 32'd1;
      step();
      step();
      idle_inputs();
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || acc !== 32'd8) begin
         n_err++; $display("FAIL mid_full got v=%0b rdy=%0b acc=%0d want 1 0 8", out_valid,
                           in_ready, acc);
      end
      #2;
      rst = 1'b1;
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || acc !== 32'd0 || in_ready !== 1'b1) begin
         n_err++; $display("FAIL mid_reset got v=%0b acc=%0d rdy=%0b want 0 0 1", out_valid,
                           acc, in_ready);
      end
      rst = 1'b0;
      out_ready = 1'b1;
      in_valid = 1'b1; in_a = 32'd2; in_b = 32'd3;
      step();
      idle_inputs();
      step();
      n_vec++;
      if (out_valid !== 1'b1 || out_sum !== 33'd5) begin
         n_err++; $display("FAIL post_reset got v=%0b s=%0d want 1 5", out_valid, out_sum);
      end
      step();
      n_vec++;
      if (out_valid !== 1'b0 || res_cnt !== 8'd1) begin
         n_err++; $display("FAIL post_reset_drain got v=%0b cnt=%0d want 0 1", out_valid,
                           res_cnt);
      end
   endtask

   task automatic test_cnt_wrap();
      pulse_reset();
      out_ready = 1'b1;
      in_valid = 1'b1; in_a = 32'd0; in_b = 32'd1;
      repeat (256) step();
      idle_inputs();
      step();
      n_vec++;
      if (res_cnt !== 8'hFF) begin
         n_err++; $display("FAIL wrap_pre got %0d want 255", res_cnt);
      end
      step();
      n_vec++;
      if (res_cnt !== 8'h00 || out_valid !== 1'b0) begin
         n_err++; $display("FAIL wrap_zero got cnt=%0d v=%0b want 0 0", res_cnt, out_valid);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b0;
      out_ready = 1'b1;
      idle_inputs();
      #2;
      test_reset();
      test_carry();
      test_overflow();
      test_acc_chain();
      test_backpressure();
      test_reset_mid();
      test_cnt_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
